k580vt57: RTL and testbench

- 4-channel DMA controller, functional equivalent of the 8257 / K580VT57.
- Sits directly upstream of the CRT controller. It services that block's drq by acquiring the bus and issuing memory-read cycles. During each cycle it asserts dack so the CRT controller latches the character byte from the data bus.
- Also serves other channels (e.g. floppy, tape) with memory-write or verify transfers.
- Programmed by the CPU through a 4-bit register address.

---
 rtl/k580vt57.sv | 213 +++++++++++++++++++++
 tb/tb_k580vt57.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k580vt57.sv
// k580vt57: 4-channel DMA controller, 8257-compatible register map and bus cycles.
// Define K580VT57_AUTOLOAD_EN to make channel 3 an autoload shadow for channel 2.
module k580vt57 #(
  parameter int CE_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        memr_n,
  output logic        memw_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        tc
);

  // state | meaning
  // IDLE  | bus released, waiting for an enabled request
  // WAIT  | hrq raised, waiting for hlda
  // S1    | address and dack driven (extended write strobe here)
  // S2    | cycle strobes asserted, tc flagged on last byte
  // S3    | strobes released, address/count updated
  // S4    | dack/tc dropped, burst on or release the bus
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_S1, ST_S2, ST_S3, ST_S4} state_t;

  state_t      st_q;
  logic [15:0] addr_q [4];
  logic [15:0] cnt_q  [4];
  logic [7:0]  mode_q;
  logic [3:0]  tcf_q;
  logic        upd_q;
  logic        ff_q;
  logic        iwe_n_q, ird_n_q;
  logic [3:0]  wa_q, ra_q;
  logic [7:0]  wd_q;
  logic [1:0]  ch_q, last_q;
  logic [7:0]  ce_q;
  logic        hrq_q, memr_n_q, memw_n_q, ior_n_q, iow_n_q, tc_q;
  logic [3:0]  dack_q;
  logic [15:0] oaddr_q;

  logic [3:0]  req;
  logic [1:0]  win, idx;
  logic        found, ce, ext_memw, ext_iow;
  logic [15:0] rsel;

  function automatic logic [15:0] put_byte(input logic [15:0] old, input logic [7:0] b,
                                           input logic hi);
    return hi ? {b, old[7:0]} : {old[15:8], b};
  endfunction

  assign req = drq & mode_q[3:0];
  assign ce  = (ce_q == 8'd0);

  // Rotating priority starts the search just after the channel serviced last.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = mode_q[4] ? 2'(last_q + 2'(i + 1)) : 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    ext_memw = mode_q[5] && (cnt_q[win][15:14] == 2'b01);
    ext_iow  = mode_q[5] && (cnt_q[win][15:14] == 2'b10);
  end

  always_comb begin
    odata = 8'd0;
    rsel  = iaddr[0] ? cnt_q[iaddr[2:1]] : addr_q[iaddr[2:1]];
    if (!iaddr[3])
      odata = ff_q ? rsel[15:8] : rsel[7:0];
    else if (iaddr == 4'd8)
      odata = {3'b000, upd_q, tcf_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      mode_q   <= '0;   tcf_q    <= '0;   upd_q    <= 1'b0; ff_q    <= 1'b0;
      iwe_n_q  <= 1'b1; ird_n_q  <= 1'b1; wa_q     <= '0;   ra_q    <= '0;
      wd_q     <= '0;   ch_q     <= '0;   last_q   <= 2'd3; ce_q    <= '0;
      hrq_q    <= 1'b0; dack_q   <= '0;   oaddr_q  <= '0;   tc_q    <= 1'b0;
      memr_n_q <= 1'b1; memw_n_q <= 1'b1; ior_n_q  <= 1'b1; iow_n_q <= 1'b1;
    end else begin
      iwe_n_q <= iwe_n;
      ird_n_q <= ird_n;
      if (!iwe_n) begin
        wa_q <= iaddr;
        wd_q <= idata;
      end
      if (!ird_n) ra_q <= iaddr;
      ce_q <= ce ? 8'(CE_DIV - 1) : ce_q - 8'd1;

      if (iwe_n && !iwe_n_q) begin
        if (!wa_q[3]) begin
          ff_q <= !ff_q;
          if (wa_q[0]) cnt_q[wa_q[2:1]]  <= put_byte(cnt_q[wa_q[2:1]], wd_q, ff_q);
          else         addr_q[wa_q[2:1]] <= put_byte(addr_q[wa_q[2:1]], wd_q, ff_q);
`ifdef K580VT57_AUTOLOAD_EN
          if (mode_q[7] && wa_q[2:1] == 2'd2) begin
            if (wa_q[0]) cnt_q[3]  <= put_byte(cnt_q[3], wd_q, ff_q);
            else         addr_q[3] <= put_byte(addr_q[3], wd_q, ff_q);
          end
`endif
        end else if (wa_q == 4'd8) begin
          mode_q <= wd_q;
          ff_q   <= 1'b0;
`ifdef K580VT57_AUTOLOAD_EN
          if (!wd_q[7]) upd_q <= 1'b0;
`endif
        end
      end

      if (ird_n && !ird_n_q) begin
        if (!ra_q[3])          ff_q  <= !ff_q;
        else if (ra_q == 4'd8) tcf_q <= 4'd0;
      end

      // DMA updates follow CPU side effects so TC flags win a same-cycle status read.
      if (ce) begin
        unique case (st_q)
          ST_IDLE: if (|req) begin
            hrq_q <= 1'b1;
            st_q  <= ST_WAIT;
          end
          ST_WAIT: if (!(|req)) begin
            hrq_q <= 1'b0;
            st_q  <= ST_IDLE;
          end else if (hlda) begin
            ch_q     <= win;
            last_q   <= win;
            oaddr_q  <= addr_q[win];
            dack_q   <= 4'b0001 << win;
            memw_n_q <= !ext_memw;
            iow_n_q  <= !ext_iow;
            st_q     <= ST_S1;
          end
          ST_S1: begin
            tc_q <= (cnt_q[ch_q][13:0] == 14'd0);
            case (cnt_q[ch_q][15:14])
              2'b01:   begin ior_n_q  <= 1'b0; memw_n_q <= 1'b0; end
              2'b10:   begin memr_n_q <= 1'b0; iow_n_q  <= 1'b0; end
              default: ;
            endcase
            st_q <= ST_S2;
          end
          ST_S2: begin
            memr_n_q <= 1'b1; memw_n_q <= 1'b1; ior_n_q <= 1'b1; iow_n_q <= 1'b1;
            st_q     <= ST_S3;
          end
          ST_S3: begin
            addr_q[ch_q]       <= addr_q[ch_q] + 16'd1;
            cnt_q[ch_q][13:0]  <= cnt_q[ch_q][13:0] - 14'd1;
            if (cnt_q[ch_q][13:0] == 14'd0) begin
              tcf_q[ch_q] <= 1'b1;
`ifdef K580VT57_AUTOLOAD_EN
              if (ch_q == 2'd2) upd_q <= mode_q[7];
              if (mode_q[7] && ch_q == 2'd2) begin
                addr_q[2] <= addr_q[3];
                cnt_q[2]  <= cnt_q[3];
              end else if (mode_q[6]) mode_q[ch_q] <= 1'b0;
`else
              if (mode_q[6]) mode_q[ch_q] <= 1'b0;
`endif
            end
            dack_q <= '0;
            tc_q   <= 1'b0;
            st_q   <= ST_S4;
          end
          ST_S4: if (|req && hlda) begin
            ch_q     <= win;
            last_q   <= win;
            oaddr_q  <= addr_q[win];
            dack_q   <= 4'b0001 << win;
            memw_n_q <= !ext_memw;
            iow_n_q  <= !ext_iow;
            st_q     <= ST_S1;
          end else begin
            hrq_q <= 1'b0;
            st_q  <= ST_IDLE;
          end
          default: st_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign hrq    = hrq_q;
  assign dack   = dack_q;
  assign oaddr  = oaddr_q;
  assign memr_n = memr_n_q;
  assign memw_n = memw_n_q;
  assign ior_n  = ior_n_q;
  assign iow_n  = iow_n_q;
  assign tc     = tc_q;

endmodule

// File: tb/tb_k580vt57.sv
// Bench for k580vt57: directed and randomized DMA blocks checked against a transfer-list model.
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  iaddr = '0;
  logic [7:0]  idata = '0;
  wire  [7:0]  odata;
  logic        iwe_n = 1'b1, ird_n = 1'b1;
  logic [3:0]  drq = '0;
  wire  [3:0]  dack;
  wire         hrq;
  logic        hlda;
  wire  [15:0] oaddr;
  wire         memr_n, memw_n, ior_n, iow_n, tc;

  k580vt57 dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
    .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .ior_n(ior_n), .iow_n(iow_n), .tc(tc)
  );

  always #5 clk = ~clk;

  logic       hlda_auto = 1'b1;
  logic [1:0] hd = '0;
  always @(posedge clk) hd <= {hd[0], hrq};
  assign hlda = hlda_auto & hd[1];

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] addr;
    logic [3:0]  stb;   // {memr, memw, ior, iow} seen active
    logic        tc;
  } xfer_t;

  xfer_t obs_q[$];
  xfer_t exp_q[$];
  xfer_t cur;
  bit    active = 0;
  int    starts = 0, tc_stray = 0, bad_dack = 0;
  int    checks = 0, errors = 0;

  logic [15:0] m_addr [4];
  int          m_len  [4];
  logic [1:0]  m_type [4];
  int          m_last = 3;
  logic [7:0]  exp_st = '0;

  always @(negedge clk) begin
    if (dack != 4'd0) begin
      if (!(dack inside {4'd1, 4'd2, 4'd4, 4'd8})) bad_dack++;
      if (!active) begin
        active   = 1;
        starts++;
        cur.ch   = dack[3] ? 2'd3 : dack[2] ? 2'd2 : dack[1] ? 2'd1 : 2'd0;
        cur.addr = oaddr;
        cur.stb  = '0;
        cur.tc   = 1'b0;
      end
      cur.stb |= {~memr_n, ~memw_n, ~ior_n, ~iow_n};
      cur.tc  |= tc;
    end else begin
      if (tc) tc_stray++;
      if (active) begin
        obs_q.push_back(cur);
        active = 0;
      end
    end
  end

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [3:0] stb_of(input logic [1:0] t);
    if (t == 2'b01) return 4'b0110;
    if (t == 2'b10) return 4'b1001;
    return 4'b0000;
  endfunction

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk); iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd8(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); iaddr = a; ird_n = 1'b0;
    @(negedge clk); d = odata; ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic prog(input int ch, input logic [15:0] a, input logic [15:0] c);
    wr8(4'(2 * ch), a[7:0]);     wr8(4'(2 * ch), a[15:8]);
    wr8(4'(2 * ch + 1), c[7:0]); wr8(4'(2 * ch + 1), c[15:8]);
    m_addr[ch] = a;
    m_len[ch]  = int'(c[13:0]) + 1;
    m_type[ch] = c[15:14];
  endtask

  // Each enabled channel delivers its whole block then drops out; the arbiter
  // picks lowest index (fixed) or the first channel after the last serviced one.
  task automatic model_run(input logic [3:0] mask, input bit rot);
    int    rem [4];
    int    pick, c;
    xfer_t e;
    for (int k = 0; k < 4; k++) rem[k] = mask[k] ? m_len[k] : 0;
    forever begin
      pick = -1;
      for (int k = 0; k < 4; k++) begin
        c = rot ? (m_last + 1 + k) % 4 : k;
        if (pick < 0 && rem[c] > 0) pick = c;
      end
      if (pick < 0) break;
      e.ch   = 2'(pick);
      e.addr = m_addr[pick];
      e.stb  = stb_of(m_type[pick]);
      e.tc   = (rem[pick] == 1);
      exp_q.push_back(e);
      if (e.tc) exp_st[pick] = 1'b1;
      m_addr[pick] = m_addr[pick] + 16'd1;
      rem[pick]--;
      m_last = pick;
    end
  endtask

  task automatic wait_starts(input int n, input string tag);
    for (int i = 0; i < 20000 && starts < n; i++) @(negedge clk);
    chk(tag, n, starts >= n, 1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int i;
    for (i = 0; i < 20000 && !(obs_q.size() >= n && hrq == 1'b0 && !active); i++)
      @(negedge clk);
    chk(tag, n, i < 20000, 1);
  endtask

  task automatic cmp_xfers(input string tag);
    chk({tag, "_n"}, 0, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_ch"},   i, obs_q[i].ch,   exp_q[i].ch);
      chk({tag, "_addr"}, i, obs_q[i].addr, exp_q[i].addr);
      chk({tag, "_stb"},  i, obs_q[i].stb,  exp_q[i].stb);
      chk({tag, "_tc"},   i, obs_q[i].tc,   exp_q[i].tc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag, input logic [7:0] after);
    logic [7:0] d;
    rd8(4'd8, d); chk(tag, 0, d, exp_st);
    exp_st = after;
    rd8(4'd8, d); chk(tag, 1, d, after);
  endtask

  task automatic block(input string tag, input logic [3:0] mask, input logic [7:0] mode);
    drq = mask;
    model_run(mask, mode[4]);
    wr8(4'd8, mode);
    wait_done(exp_q.size(), {tag, "_done"});
    cmp_xfers(tag);
    repeat (6) @(negedge clk);
    chk({tag, "_hold_off"}, 0, hrq, 1'b0);
    drq = '0;
    chk_status({tag, "_st"}, 8'h00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] cv;
    int          s0, c1, c2;
    logic [3:0]  mask;
    logic [7:0]  mode;

    repeat (3) @(negedge clk);
    chk("rst_dack", 0, dack, 4'd0);
    chk("rst_hrq", 0, hrq, 1'b0);
    chk("rst_strobes", 0, {memr_n, memw_n, ior_n, iow_n}, 4'hF);
    chk("rst_tc", 0, tc, 1'b0);
    chk("rst_oaddr", 0, oaddr, 16'h0000);
    reset = 1'b0;
    chk_status("rst_status", 8'h00);

    // 80-byte block on channel 2, no TC stop: requester withdraws after the last byte.
    wr8(4'd8, 8'h00);
    prog(2, 16'h76D0, 16'h404F);
    drq = 4'b0100;
    model_run(4'b0100, 1'b0);
    wr8(4'd8, 8'h04);
    wait_starts(80, "blk80_start");
    drq = '0;
    wait_done(80, "blk80_done");
    cmp_xfers("blk80");
    chk("blk80_tc_stray", 0, tc_stray, 0);
    cv = 16'((int'(16'h004F) - 80) & 16'h3FFF) | 16'h4000;
    rd8(4'd4, d); chk("blk80_addr_lo", 0, d, m_addr[2][7:0]);
    rd8(4'd4, d); chk("blk80_addr_hi", 0, d, m_addr[2][15:8]);
    rd8(4'd5, d); chk("blk80_cnt_lo", 0, d, cv[7:0]);
    rd8(4'd5, d); chk("blk80_cnt_hi", 0, d, cv[15:8]);
    chk_status("blk80_st", 8'h00);

    wr8(4'd8, 8'h00);
    prog(0, 16'h1000, 16'h8005);
    prog(2, 16'h2000, 16'h8005);
    block("fixed", 4'b0101, 8'h45);

    wr8(4'd8, 8'h00);
    prog(0, 16'h3000, 16'h8003);
    prog(2, 16'h4000, 16'h4003);
    block("rotate", 4'b0101, 8'h55);

    wr8(4'd8, 8'h00);
    prog(2, 16'h1234, 16'h4001);
    block("tcstop", 4'b0100, 8'h44);

    wr8(4'd8, 8'h00);
    prog(2, 16'hFFFF, 16'h8001);
    block("wrap", 4'b0100, 8'h44);

    for (int r = 0; r < 8; r++) begin
      wr8(4'd8, 8'h00);
      c1   = $urandom_range(0, 3);
      c2   = $urandom_range(0, 3);
      mask = 4'((1 << c1) | (1 << c2));
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          cv = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                           : 16'($urandom);
          prog(c, cv, {2'($urandom_range(0, 3)), 14'($urandom_range(0, 4))});
        end
      end
      mode = 8'h40 | 8'(mask) | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 1) << 5);
      block("rand", mask, mode);
    end

    // Request withdrawn while waiting for the bus.
    wr8(4'd8, 8'h00);
    hlda_auto = 1'b0;
    prog(2, 16'h5000, 16'h80FF);
    s0  = starts;
    drq = 4'b0100;
    wr8(4'd8, 8'h04);
    for (int i = 0; i < 50 && hrq !== 1'b1; i++) @(negedge clk);
    chk("wait_hrq_up", 0, hrq, 1'b1);
    drq = '0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_hrq_down", 0, hrq, 1'b0);
    chk("wait_no_dack", 0, starts, s0);
    chk("wait_dack", 0, dack, 4'd0);

    // Reset in the middle of a read cycle.
    hlda_auto = 1'b1;
    drq = 4'b0100;
    for (int i = 0; i < 100 && memr_n !== 1'b0; i++) @(negedge clk);
    chk("s2_memr", 0, memr_n, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_memr", 0, memr_n, 1'b1);
    chk("mid_rst_iow", 0, iow_n, 1'b1);
    chk("mid_rst_dack", 0, dack, 4'd0);
    chk("mid_rst_hrq", 0, hrq, 1'b0);
    chk("mid_rst_tc", 0, tc, 1'b0);
    chk("mid_rst_oaddr", 0, oaddr, 16'h0000);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_mode", 0, hrq, 1'b0);
    drq = '0;
    obs_q.delete();
    m_last = 3;
    exp_st = '0;
    chk_status("mid_rst_st", 8'h00);

`ifdef K580VT57_AUTOLOAD_EN
    wr8(4'd8, 8'h00);
    prog(3, 16'h76D0, 16'h4003);
    prog(2, 16'h76D0, 16'h4003);
    drq = 4'b0100;
    model_run(4'b0100, 1'b0);
    m_addr[2] = 16'h76D0;
    m_len[2]  = 2;
    model_run(4'b0100, 1'b0);
    exp_q[5].tc = 1'b0;
    exp_st = 8'h14;
    wr8(4'd8, 8'h84);
    wait_starts(6, "auto_start");
    drq = '0;
    wait_done(6, "auto_done");
    cmp_xfers("auto");
    chk_status("auto_st", 8'h10);
`endif

    chk("tc_stray", 0, tc_stray, 0);
    chk("dack_onehot", 0, bad_dack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
